// File: rtl/register_file_mp_if.sv
// Register file bus: decode-side reads and reservations, writeback-side writes.
// The master drives addresses, write requests and reserve requests. The slave
// (the register file) returns read data, busy flags and the reserve conflict.
// There is no valid/ready handshake. An enable that is high at a rising edge
// is always accepted on that edge, and reads are combinational.
interface register_file_mp_if #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NREG);

  logic [NUM_RD*AW-1:0] RFr_addr;
  logic [NUM_RD*DW-1:0] RFr_data;
  logic [NUM_RD-1:0]    RFr_busy;
  logic                 RFw0_en;
  logic [AW-1:0]        RFw0_addr;
  logic [DW-1:0]        RFw0_data;
  logic                 RFw1_en;
  logic [AW-1:0]        RFw1_addr;
  logic [DW-1:0]        RFw1_data;
  logic                 RFres_en;
  logic [AW-1:0]        RFres_addr;
  logic                 RFres_conflict;
  logic [NREG-1:0]      RFbusy_vec;

  modport master (
    output RFr_addr, RFw0_en, RFw0_addr, RFw0_data,
    output RFw1_en, RFw1_addr, RFw1_data, RFres_en, RFres_addr,
    input  RFr_data, RFr_busy, RFres_conflict, RFbusy_vec
  );

  modport slave (
    input  RFr_addr, RFw0_en, RFw0_addr, RFw0_data,
    input  RFw1_en, RFw1_addr, RFw1_data, RFres_en, RFres_addr,
    output RFr_data, RFr_busy, RFres_conflict, RFbusy_vec
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// W0 is the ALU writeback path. W1 is the long-latency path and wins collisions.
// A reserve marks a register busy until a later write clears it.
module register_file_mp #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  register_file_mp_if.slave  rf
);
  localparam int AW = $clog2(NREG);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            conflict_q, conflict_d;

  // Requests that actually touch state. With ZERO_REG set, r0 is hardwired.
  logic w0_ok, w1_ok, res_ok;

  // Qualify write/reserve requests against the hardwired zero register
  always_comb begin
    w0_ok  = rf.RFw0_en  && !((ZERO_REG != 0) && (rf.RFw0_addr  == '0));
    w1_ok  = rf.RFw1_en  && !((ZERO_REG != 0) && (rf.RFw1_addr  == '0));
    res_ok = rf.RFres_en && !((ZERO_REG != 0) && (rf.RFres_addr == '0));
  end

  // Next state: W1 is applied after W0 so it wins, and reserve is applied after writes so it wins
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w0_ok) begin
      regs_d[rf.RFw0_addr] = rf.RFw0_data;
      busy_d[rf.RFw0_addr] = 1'b0;
    end
    if (w1_ok) begin
      regs_d[rf.RFw1_addr] = rf.RFw1_data;
      busy_d[rf.RFw1_addr] = 1'b0;
    end
    if (res_ok) begin
      busy_d[rf.RFres_addr] = 1'b1;
    end
    conflict_d = res_ok && busy_q[rf.RFres_addr];
  end

  // State registers; reset drops any write pending in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  logic [AW-1:0]     rd_addr [NUM_RD];
  logic [NUM_RD-1:0] hit_w0, hit_w1, hit_res;

  // Combinational read ports with optional same-cycle bypass from the write ports
  always_comb begin
    rf.RFr_data = '0;
    rf.RFr_busy = '0;
    hit_w0      = '0;
    hit_w1      = '0;
    hit_res     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = rf.RFr_addr[k*AW +: AW];
      hit_w0[k]  = rf.RFw0_en  && (rf.RFw0_addr  == rd_addr[k]);
      hit_w1[k]  = rf.RFw1_en  && (rf.RFw1_addr  == rd_addr[k]);
      hit_res[k] = rf.RFres_en && (rf.RFres_addr == rd_addr[k]);

      if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
        rf.RFr_data[k*DW +: DW] = '0;
      end else if ((BYPASS != 0) && hit_w1[k]) begin
        rf.RFr_data[k*DW +: DW] = rf.RFw1_data;
      end else if ((BYPASS != 0) && hit_w0[k]) begin
        rf.RFr_data[k*DW +: DW] = rf.RFw0_data;
      end else begin
        rf.RFr_data[k*DW +: DW] = regs_q[rd_addr[k]];
      end

      // A bypassed write means the producer is done, unless a new producer reserves it now
      if ((BYPASS != 0) && (hit_w0[k] || hit_w1[k]) && !hit_res[k]) begin
        rf.RFr_busy[k] = 1'b0;
      end else begin
        rf.RFr_busy[k] = busy_q[rd_addr[k]];
      end
    end
  end

  assign rf.RFbusy_vec     = busy_q;
  assign rf.RFres_conflict = conflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp. Two instances share one stimulus stream, one with
// bypass and one without. A behavioural model holds the architectural register
// and busy state, and a negedge process compares both DUTs against it.
module tb_register_file_mp;
  localparam int DW     = 32;
  localparam int NREG   = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  register_file_mp_if #(.DW(DW), .NREG(NREG), .NUM_RD(NUM_RD)) bus_b ();
  register_file_mp_if #(.DW(DW), .NREG(NREG), .NUM_RD(NUM_RD)) bus_n ();

  // The no-bypass instance sees exactly the same requests
  assign bus_n.RFr_addr   = bus_b.RFr_addr;
  assign bus_n.RFw0_en    = bus_b.RFw0_en;
  assign bus_n.RFw0_addr  = bus_b.RFw0_addr;
  assign bus_n.RFw0_data  = bus_b.RFw0_data;
  assign bus_n.RFw1_en    = bus_b.RFw1_en;
  assign bus_n.RFw1_addr  = bus_b.RFw1_addr;
  assign bus_n.RFw1_data  = bus_b.RFw1_data;
  assign bus_n.RFres_en   = bus_b.RFres_en;
  assign bus_n.RFres_addr = bus_b.RFres_addr;

  register_file_mp #(.DW(DW), .NREG(NREG), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(1))
    dut_b (.clk(clk), .rst_n(rst_n), .rf(bus_b));
  register_file_mp #(.DW(DW), .NREG(NREG), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(0))
    dut_n (.clk(clk), .rst_n(rst_n), .rf(bus_n));

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem  [NREG];
  bit            m_busy [NREG];
  bit            m_conf;

  // Architectural state after each edge: data written, producers tracked
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
      m_conf <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        bool_upd(i);
      end
      m_conf <= bus_b.RFres_en && (bus_b.RFres_addr != 0) && m_busy[bus_b.RFres_addr];
    end
  end

  // Per-register view: which value lands in register i and whether it stays busy
  task automatic bool_upd(input int i);
    bit wr0 = bus_b.RFw0_en && (int'(bus_b.RFw0_addr) == i);
    bit wr1 = bus_b.RFw1_en && (int'(bus_b.RFw1_addr) == i);
    bit rs  = bus_b.RFres_en && (int'(bus_b.RFres_addr) == i);
    if (wr1)      m_mem[i] <= bus_b.RFw1_data;
    else if (wr0) m_mem[i] <= bus_b.RFw0_data;
    if (rs)              m_busy[i] <= 1'b1;
    else if (wr0 || wr1) m_busy[i] <= 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && bus_b.RFw1_en && bus_b.RFw1_addr == a) return bus_b.RFw1_data;
    if (byp && bus_b.RFw0_en && bus_b.RFw0_addr == a) return bus_b.RFw0_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    bit wr = (bus_b.RFw0_en && bus_b.RFw0_addr == a) || (bus_b.RFw1_en && bus_b.RFw1_addr == a);
    bit rs = bus_b.RFres_en && bus_b.RFres_addr == a;
    if (byp && wr && !rs) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NREG-1:0] exp_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the model on every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NUM_RD; k++) begin
        logic [AW-1:0] a;
        a = bus_b.RFr_addr[k*AW +: AW];
        check($sformatf("cyc_rdata_byp%0d", k), bus_b.RFr_data[k*DW +: DW], exp_read(a, 1'b1));
        check($sformatf("cyc_rdata_nob%0d", k), bus_n.RFr_data[k*DW +: DW], exp_read(a, 1'b0));
        check($sformatf("cyc_rbusy_byp%0d", k), bus_b.RFr_busy[k], exp_busy(a, 1'b1));
        check($sformatf("cyc_rbusy_nob%0d", k), bus_n.RFr_busy[k], exp_busy(a, 1'b0));
      end
      check("cyc_busy_vec_byp", bus_b.RFbusy_vec, exp_vec());
      check("cyc_busy_vec_nob", bus_n.RFbusy_vec, exp_vec());
      check("cyc_conflict_byp", bus_b.RFres_conflict, m_conf);
      check("cyc_conflict_nob", bus_n.RFres_conflict, m_conf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                       input bit w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                       input bit re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rd0, input logic [AW-1:0] rd1);
    bus_b.RFw0_en    = w0e;
    bus_b.RFw0_addr  = w0a;
    bus_b.RFw0_data  = w0d;
    bus_b.RFw1_en    = w1e;
    bus_b.RFw1_addr  = w1a;
    bus_b.RFw1_data  = w1d;
    bus_b.RFres_en   = re;
    bus_b.RFres_addr = ra;
    bus_b.RFr_addr   = {rd1, rd0};
  endtask

  task automatic idle(input logic [AW-1:0] rd0, input logic [AW-1:0] rd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, rd0, rd1);
  endtask

  // One rising edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle(5'd5, 5'd31);

    // 1. reset pulse before any clock edge
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    #2;
    check("rst_r5",       bus_b.RFr_data[0 +: DW],  32'h0);
    check("rst_r31",      bus_b.RFr_data[DW +: DW], 32'h0);
    check("rst_busy_vec", bus_b.RFbusy_vec,         32'h0);
    check("rst_conflict", bus_b.RFres_conflict,     1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 2. write r7 and read it in the same cycle
    drive(1, 5'd7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    #1;
    check("byp_r7_now",   bus_b.RFr_data[0 +: DW], 32'hDEADBEEF);
    check("nobyp_r7_now", bus_n.RFr_data[0 +: DW], 32'h0);
    tick();
    idle(5'd7, 5'd0);
    #1;
    check("nobyp_r7_next", bus_n.RFr_data[0 +: DW], 32'hDEADBEEF);

    // 3. dual-write collision, then two distinct addresses
    drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0, 0, 5'd3, 5'd4);
    tick();
    idle(5'd3, 5'd4);
    #1;
    check("collide_r3",       bus_n.RFr_data[0 +: DW], 32'h22);
    check("model_collide_r3", m_mem[3],                32'h22);
    drive(1, 5'd4, 32'h44, 1, 5'd3, 32'h55, 0, 0, 5'd3, 5'd4);
    tick();
    idle(5'd3, 5'd4);
    #1;
    check("split_r3", bus_n.RFr_data[0 +: DW],  32'h55);
    check("split_r4", bus_n.RFr_data[DW +: DW], 32'h44);

    // 4. zero register: write and reserve r0
    drive(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd0, 5'd0);
    #1;
    check("r0_byp_now", bus_b.RFr_data[0 +: DW], 32'h0);
    tick();
    idle(5'd0, 5'd9);
    #1;
    check("r0_read",     bus_b.RFr_data[0 +: DW], 32'h0);
    check("r0_busy",     bus_b.RFbusy_vec[0],     1'b0);
    check("r0_conflict", bus_b.RFres_conflict,    1'b0);

    // 5. scoreboard sequence on r9
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    tick();
    check("r9_busy_set", bus_b.RFbusy_vec[9],  1'b1);
    check("r9_no_conf",  bus_b.RFres_conflict, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    tick();
    check("r9_conf",       bus_b.RFres_conflict, 1'b1);
    check("model_r9_conf", m_conf,               1'b1);
    idle(5'd9, 5'd0);
    tick();
    check("r9_conf_drop",  bus_b.RFres_conflict, 1'b0);
    check("r9_still_busy", bus_b.RFbusy_vec[9],  1'b1);
    drive(0, 0, 0, 1, 5'd9, 32'h5, 0, 0, 5'd9, 5'd0);
    #1;
    check("r9_rbusy_byp", bus_b.RFr_busy[0], 1'b0);
    check("r9_rbusy_nob", bus_n.RFr_busy[0], 1'b1);
    tick();
    check("r9_busy_clr", bus_b.RFbusy_vec[9], 1'b0);
    drive(1, 5'd9, 32'h77, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0);
    tick();
    idle(5'd9, 5'd0);
    #1;
    check("r9_res_wins",  bus_b.RFbusy_vec[9],     1'b1);
    check("r9_data_w0",   bus_n.RFr_data[0 +: DW], 32'h77);
    check("r9_conf_none", bus_b.RFres_conflict,    1'b0);

    // Compact vector table; the per-cycle compare checks every row
    drive(1, 5'd10, 32'hA5A5_0001, 1, 5'd11, 32'h5A5A_0002, 1, 5'd12, 5'd10, 5'd11);
    tick();
    drive(1, 5'd12, 32'h0000_1234, 0, 0, 0, 1, 5'd12, 5'd12, 5'd10);
    tick();
    drive(0, 0, 0, 1, 5'd12, 32'hCAFE_F00D, 1, 5'd31, 5'd12, 5'd31);
    tick();
    drive(1, 5'd31, 32'h1, 1, 5'd31, 32'h2, 1, 5'd31, 5'd31, 5'd12);
    tick();
    drive(1, 5'd0, 32'h3, 0, 0, 0, 1, 5'd11, 5'd0, 5'd11);
    tick();
    idle(5'd31, 5'd11);
    tick();
    check("tbl_r31", bus_n.RFr_data[0 +: DW],  32'h2);
    check("tbl_r11", bus_n.RFr_data[DW +: DW], 32'h5A5A_0002);

    // 6. reset lands with a write pending
    drive(1, 5'd12, 32'hA, 0, 0, 0, 1, 5'd12, 5'd12, 5'd0);
    tick();
    drive(1, 5'd12, 32'hB, 0, 0, 0, 0, 0, 5'd12, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_r12_nob",  bus_n.RFr_data[0 +: DW], 32'h0);
    check("mid_rst_r12_byp",  bus_b.RFr_data[0 +: DW], 32'hB);
    check("mid_rst_busy_vec", bus_b.RFbusy_vec,        32'h0);
    tick();
    idle(5'd12, 5'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_r12_byp", bus_b.RFr_data[0 +: DW], 32'h0);
    check("post_rst_r12_nob", bus_n.RFr_data[0 +: DW], 32'h0);
    check("post_rst_busy12",  bus_b.RFbusy_vec[12],    1'b0);
    tick();

    // ---------------- final report ----------------
    cmp_en = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-cycle core's 32x32 register file.
- Provides NUM_RD combinational read ports and two write ports, each with priority resolution and optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard (reserve on issue, clear on writeback) so multicycle units (mul/div, load) can share the file with the pipeline.
- Sits between decode (reads, reserve) and writeback (W0 = ALU path, W1 = long-latency path).

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers; power of two, ≥4.
- AW, $clog2(NREG), address width; derived, do not override.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1, 1 = a read returns the write data being written to the same address in the same cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RFr_addr  in  NUM_RD*AW  read addresses; port k is at [k*AW +: AW].
- RFr_data  out  NUM_RD*DW  read data; port k is at [k*DW +: DW].
- RFr_busy  out  NUM_RD  busy flag of each read address, after bypass.
- RFw0_en  in  1  write port 0 enable.
- RFw0_addr  in  AW  write port 0 address.
- RFw0_data  in  DW  write port 0 data.
- RFw1_en  in  1  write port 1 enable (priority port).
- RFw1_addr  in  AW  write port 1 address.
- RFw1_data  in  DW  write port 1 data.
- RFres_en  in  1  reserve request; sets the busy bit of RFres_addr.
- RFres_addr  in  AW  register to reserve.
- RFres_conflict  out  1  registered; pulses 1 cycle after reserving an already-busy register.
- RFbusy_vec  out  NREG  registered busy bits, bit i = register i.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers = 0, all busy bits = 0, RFres_conflict = 0.
  - Reset may assert mid-operation; all state clears immediately, and in-flight writes that cycle are lost.
  - Release is synchronous to the first rising edge with rst_n=1.
- Writes: committed on the rising edge.
  - Both ports enabled to the same address: W1 data is stored and W0 is dropped.
  - Different addresses: both are stored.
- ZERO_REG=1:
  - writes to address 0 are discarded.
  - reads of address 0 return 0.
  - reserve of address 0 is ignored (no busy, no conflict).
- Reads are combinational, zero latency.
  - BYPASS=1: if W1 is writing the read address this cycle, return RFw1_data; else if W0 is, return RFw0_data; else return the stored value.
  - BYPASS=0: always return the stored value; the new value is visible the cycle after the edge.
  - ZERO_REG overrides bypass for address 0.
- Busy scoreboard, per register, updated on the rising edge:
  - a write (either port) to a register clears its busy bit.
  - a reserve sets it.
  - reserve and write to the same register in the same cycle: reserve wins, busy = 1 (new producer supersedes).
  - RFr_busy[k] = busy[addr_k], except it is 0 when BYPASS=1 and a write to addr_k is present this cycle without a same-cycle reserve of addr_k.
- RFres_conflict is set to 1 on the edge where a reserve targets a register whose busy bit is already 1, and is 0 otherwise. The reservation still takes effect (busy stays 1).
- Address width rule: NREG is a power of two, so every address is valid and there is no out-of-range case.
- No X propagation: uninitialised state is impossible after reset.

Test Plan:
1. Reset then read: pulse rst_n low mid-cycle, then read r5 and r31 → RFr_data = 0, RFbusy_vec = 0, RFres_conflict = 0, with no clock edge required.
2. Write 0xDEADBEEF to r7 via W0 and read r7 on port 0 in the same cycle:
   - BYPASS=1 → 0xDEADBEEF immediately.
   - BYPASS=0 → 0 now, 0xDEADBEEF the next cycle.
3. Dual-write collision: W0 writes (r3, 0x11) and W1 writes (r3, 0x22) in the same cycle → r3 = 0x22. Separate addresses (r3, r4) → both values stored.
4. Zero register: W1 writes (r0, 0xFFFF_FFFF) and reserves r0 → r0 reads 0, RFbusy_vec[0] = 0, RFres_conflict = 0.
5. Scoreboard sequence:
   - reserve r9 → busy[9] = 1.
   - reserve r9 again → RFres_conflict = 1 for one cycle.
   - W1 writes r9 = 0x5 → busy[9] = 0.
   - reserve r9 plus W0 write to r9 in the same cycle → busy[9] = 1 and r9 = that W0 data.
6. Reset mid-operation: reserve r12 and write r12 = 0xA, then assert rst_n with the next write pending → r12 = 0, busy[12] = 0, and the pending write is not committed.
